// File: rtl/ifetch_queue.sv
// Instruction fetch front end: single-outstanding memory reads feeding a
// show-ahead queue that presents one instruction per cycle to the IR.

module ifetch_queue_chk (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_full
);

  // a push into a full queue means the request gating is broken
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(i_push && i_full))
    else $error("ifetch_queue: push into full queue");

endmodule

module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        ir_load,
  output logic [15:0] ir_word,
  output logic [15:0] ir_pc,
  output logic        empty
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [15:0]    r_fetch_pc;
  logic [15:0]    w_fetch_pc_nxt;
  logic [15:0]    r_addr;
  logic [15:0]    w_addr_nxt;
  logic [15:0]    r_word [DEPTH];
  logic [15:0]    r_pc   [DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [AW:0]    r_count;
  logic [AW:0]    w_count_nxt;
  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic [15:0]    w_redirect_pc;

  assign w_empty       = (r_count == '0);
  assign w_redirect_pc = {redirect_pc[15:1], 1'b0};
  assign w_push        = (r_state == REQ) && mem_resp && !redirect;
  assign w_pop         = ir_load;

  assign mem_read    = (r_state == REQ) || (r_state == DISCARD);
  assign mem_address = r_addr;
  assign empty       = w_empty;
  assign ir_load     = !w_empty && !stall && !redirect;
  assign ir_word     = w_empty ? 16'h0000 : r_word[r_head];
  assign ir_pc       = w_empty ? 16'h0000 : r_pc[r_head];

  // occupancy after this edge; a redirect empties the queue outright
  always_comb begin
    w_count_nxt = r_count;
    if (redirect) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + (AW + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (AW + 1)'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // fetch FSM next state, fetch PC and request address
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
        end else if (r_count < DEPTH_C) begin
          w_state_nxt = REQ;
          w_addr_nxt  = r_fetch_pc;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (mem_resp && redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = IDLE;
        end else if (mem_resp) begin
          w_fetch_pc_nxt = r_fetch_pc + 16'd2;
          if (w_count_nxt < DEPTH_C) begin
            w_addr_nxt = r_fetch_pc + 16'd2;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (redirect) begin
          // the read cannot be withdrawn; its data is dropped on arrival
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = DISCARD;
        end else begin
          w_state_nxt = REQ;
        end
      end
      DISCARD: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
        end else begin
          w_fetch_pc_nxt = r_fetch_pc;
        end
        if (mem_resp) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DISCARD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, fetch PC and latched request address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC & 16'hFFFE;
      r_addr     <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  // queue storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i] <= 16'h0000;
        r_pc[i]   <= 16'h0000;
      end
    end else if (redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_word[r_tail] <= mem_rdata;
        r_pc[r_tail]   <= r_addr;
        r_tail         <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  ifetch_queue_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_full (r_count == DEPTH_C)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a latency-programmable memory model, a
// negedge monitor predicting every delivery, and directed redirect/stall cases.

module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [15:0] redirect_pc;
  logic        mem_read, mem_resp, ir_load, empty;
  logic [15:0] mem_address, mem_rdata, ir_word, ir_pc;

  logic        w_mem_read, w_mem_resp, w_ir_load, w_empty;
  logic [15:0] w_mem_address, w_mem_rdata, w_ir_word, w_ir_pc;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_resp = 0;
  int          mem_lat = 0;
  int          pend = 0;

  logic [31:0] sbq [$];
  logic [15:0] waddrs [$];
  logic [15:0] exp_addr, pend_pc, prev_addr;
  logic        disc, exp_load, prev_rd, prev_resp, have_prev;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_read(mem_read), .mem_address(mem_address),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .ir_load(ir_load),
    .ir_word(ir_word), .ir_pc(ir_pc), .empty(empty)
  );

  ifetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(16'h0000), .mem_read(w_mem_read), .mem_address(w_mem_address),
    .mem_resp(w_mem_resp), .mem_rdata(w_mem_rdata), .ir_load(w_ir_load),
    .ir_word(w_ir_word), .ir_pc(w_ir_pc), .empty(w_empty)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // memory: answers after mem_lat waiting cycles with word = address ^ A5A5
  always @(posedge clk) begin
    #1;
    if (mem_read) begin
      if (pend >= mem_lat) begin
        mem_resp  = 1'b1;
        mem_rdata = mem_address ^ 16'hA5A5;
        pend      = 0;
      end else begin
        mem_resp = 1'b0;
        pend     = pend + 1;
      end
    end else begin
      mem_resp = 1'b0;
      pend     = 0;
    end
  end

  // zero-wait memory for the wrap-around instance
  always @(posedge clk) begin
    #1;
    w_mem_resp  = w_mem_read;
    w_mem_rdata = w_mem_address ^ 16'hA5A5;
  end

  // record the wrap instance's completed read addresses
  always @(negedge clk) begin
    if (reset) waddrs.delete();
    else if (w_mem_resp) waddrs.push_back(w_mem_address);
  end

  // monitor: predict queue contents and fetch addresses, compare each cycle
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      exp_addr  = 16'h0000;
      disc      = 1'b0;
      have_prev = 1'b0;
    end else begin
      exp_load = (sbq.size() != 0) && !stall && !redirect;
      check_eq("ir_load", 16'(ir_load), 16'(exp_load));
      check_eq("empty", 16'(empty), 16'(sbq.size() == 0));
      if (sbq.size() != 0) begin
        check_eq("ir_word", ir_word, sbq[0][31:16]);
        check_eq("ir_pc", ir_pc, sbq[0][15:0]);
      end else begin
        check_eq("ir_word_empty", ir_word, 16'h0000);
        check_eq("ir_pc_empty", ir_pc, 16'h0000);
      end
      if (have_prev && prev_rd && !prev_resp) begin
        check_eq("read_hold", 16'(mem_read), 16'h0001);
        check_eq("addr_hold", mem_address, prev_addr);
      end
      if (mem_resp) begin
        check_eq("mem_addr", mem_address, exp_addr);
        n_resp++;
      end
      if (exp_load) void'(sbq.pop_front());
      if (redirect) sbq.delete();
      if (mem_resp) begin
        if (!disc && !redirect) begin
          sbq.push_back({exp_addr ^ 16'hA5A5, exp_addr});
          exp_addr = exp_addr + 16'd2;
        end else if (disc) begin
          exp_addr = pend_pc;
        end
        disc = 1'b0;
        if (redirect) exp_addr = redirect_pc & 16'hFFFE;
      end else if (redirect) begin
        if (mem_read) begin
          disc    = 1'b1;
          pend_pc = redirect_pc & 16'hFFFE;
        end else begin
          exp_addr = redirect_pc & 16'hFFFE;
        end
      end
      prev_rd   = mem_read;
      prev_resp = mem_resp;
      prev_addr = mem_address;
      have_prev = 1'b1;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    n_resp = 0;
  endtask

  task automatic wait_resp(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mem_resp) got = 1'b1;
    end
    if (!got) check_eq(tag, 16'h0000, 16'h0001);
  endtask

  initial begin
    logic [15:0] wexp [4];
    bit found;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    w_mem_resp = 1'b0; w_mem_rdata = 16'h0000;

    // reset values, first request, streaming at one word per cycle
    mem_lat = 0;
    do_reset();
    @(negedge clk);
    check_eq("rst_mem_read", 16'(mem_read), 16'h0000);
    check_eq("rst_mem_addr", mem_address, 16'h0000);
    check_eq("rst_ir_load", 16'(ir_load), 16'h0000);
    check_eq("rst_empty", 16'(empty), 16'h0001);
    @(negedge clk);
    check_eq("first_read", 16'(mem_read), 16'h0001);
    check_eq("first_addr", mem_address, 16'h0000);
    repeat (20) @(negedge clk);

    // stall held: four reads fill the queue, then fetch stops
    stall = 1'b1;
    do_reset();
    repeat (20) @(negedge clk);
    check_eq("stall_reads", 16'(n_resp), 16'd4);
    check_eq("stall_idle", 16'(mem_read), 16'h0000);
    @(posedge clk); #1;
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 4) check_eq("drain_load", 16'(ir_load), 16'h0001);
      if (mem_resp && !found) begin
        check_eq("resume_addr", mem_address, 16'h0008);
        found = 1'b1;
      end
    end
    if (!found) check_eq("resume_timeout", 16'h0000, 16'h0001);

    // redirect while the read of 0004 is outstanding
    mem_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_read && mem_address == 16'h0004) found = 1'b1;
    end
    if (!found) check_eq("req4_timeout", 16'h0000, 16'h0001);
    @(posedge clk); #2;
    redirect = 1'b1; redirect_pc = 16'h3001;
    @(negedge clk);
    check_eq("redir_no_load", 16'(ir_load), 16'h0000);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check_eq("redir_empty", 16'(empty), 16'h0001);
    check_eq("redir_held_read", 16'(mem_read), 16'h0001);
    check_eq("redir_held_addr", mem_address, 16'h0004);
    wait_resp("discard_timeout");
    check_eq("discard_addr", mem_address, 16'h0004);
    wait_resp("newpc_timeout");
    check_eq("newpc_addr", mem_address, 16'h3000);
    repeat (6) @(negedge clk);

    // redirect coinciding with mem_resp and a deliverable head
    mem_lat = 0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #2;
      if (mem_resp && !empty) found = 1'b1;
    end
    if (!found) check_eq("same_timeout", 16'h0000, 16'h0001);
    redirect = 1'b1; redirect_pc = 16'h1235;
    @(negedge clk);
    check_eq("same_no_load", 16'(ir_load), 16'h0000);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check_eq("same_empty", 16'(empty), 16'h0001);
    wait_resp("same_newpc_timeout");
    check_eq("same_newpc_addr", mem_address, 16'h1234);
    repeat (4) @(negedge clk);

    // synchronous reset in the middle of a request
    mem_lat = 3; stall = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (n_resp >= 1 && mem_read && !mem_resp) found = 1'b1;
    end
    if (!found) check_eq("midreq_timeout", 16'h0000, 16'h0001);
    check_eq("midreq_not_empty", 16'(empty), 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midreq_read", 16'(mem_read), 16'h0000);
    check_eq("midreq_empty", 16'(empty), 16'h0001);
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0;

    // wrap-around of the fetch PC from RESET_PC=FFFC
    repeat (10) @(negedge clk);
    wexp[0] = 16'hFFFC; wexp[1] = 16'hFFFE; wexp[2] = 16'h0000; wexp[3] = 16'h0002;
    check_eq("wrap_count_ok", 16'(waddrs.size() >= 4), 16'h0001);
    for (int i = 0; i < 4; i++) begin
      if (i < waddrs.size()) check_eq("wrap_addr", waddrs[i], wexp[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
